// File: rtl/mult_pkg.sv
// Shared types and arithmetic helpers for the multiplier / product accumulator slice.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

    // Widest accumulator the add helper supports; callers zero-extend into this width.
    localparam int ADD_MAX_W = 64;

    function automatic logic [ADD_MAX_W:0] add_with_carry(
        input logic [ADD_MAX_W-1:0] a,
        input logic [ADD_MAX_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Accumulates COUNT multiplier products into a dot-product sum with a sticky overflow flag.
// Build option: PRODUCT_ACCUMULATOR_SAT_EN makes the accumulator saturate instead of wrap.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 2*WIDTH+2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2*WIDTH-1:0]         prod,
    input  logic                       prod_valid,
    output logic                       prod_ready,
    output logic [ACC_WIDTH-1:0]       sum,
    output logic                       sum_valid,
    input  logic                       sum_ready,
    output logic                       overflow,
    output logic                       busy,
    output logic [$clog2(COUNT+1)-1:0] beat_cnt
);

    localparam int CNT_W = $clog2(COUNT+1);

    acc_state_t           state_q;
    acc_state_t           state_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] sum_q;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic                 overflow_q;
    logic [ADD_MAX_W:0]   add_full;
    logic                 carry;
    logic                 restart;
    logic                 beat;
    logic                 last_beat;

    // Operands are zero-extended, so every bit at or above ACC_WIDTH is part of the carry-out.
    assign add_full = add_with_carry(ADD_MAX_W'(acc_q), ADD_MAX_W'(prod));
    assign carry    = |add_full[ADD_MAX_W:ACC_WIDTH];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    assign acc_next = carry ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
    assign acc_next = add_full[ACC_WIDTH-1:0];
`endif

    // A start in the same cycle as a beat wins: the beat is dropped.
    assign restart   = start && (state_q != DONE);
    assign beat      = prod_valid && prod_ready && !start;
    assign last_beat = beat && (beat_cnt_q == CNT_W'(COUNT-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (!start && last_beat) state_d = DONE;
            DONE:    if (sum_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = 1'b0;
        sum_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ACCUM: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                sum_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // The result register only loads on the final beat, so it stays stable through DONE and after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            sum_q      <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (restart) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (beat) begin
            acc_q      <= acc_next;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (carry) overflow_q <= 1'b1;
            if (last_beat) sum_q <= acc_next;
        end
    end

    assign sum      = sum_q;
    assign beat_cnt = beat_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised directed bench for product_accumulator, checking a wide (10-bit) and a narrow (9-bit) instance.
module tb_product_accumulator;

    localparam int WIDTH   = 4;
    localparam int COUNT   = 4;
    localparam int ACC_W_A = 10;
    localparam int ACC_W_B = 9;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               prod_valid;
    logic               sum_ready;
    logic [2*WIDTH-1:0] prod;

    logic               prod_ready_a, sum_valid_a, overflow_a, busy_a;
    logic [ACC_W_A-1:0] sum_a;
    logic [2:0]         beat_cnt_a;
    logic               prod_ready_b, sum_valid_b, overflow_b, busy_b;
    logic [ACC_W_B-1:0] sum_b;
    logic [2:0]         beat_cnt_b;

    int checks_total;
    int checks_passed;

    bit m_active, m_done;
    int m_cnt;
    int m_acc_a, m_acc_b, m_sum_a, m_sum_b;
    bit m_ovf_a, m_ovf_b;

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_W_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_a), .sum(sum_a), .sum_valid(sum_valid_a), .sum_ready(sum_ready),
        .overflow(overflow_a), .busy(busy_a), .beat_cnt(beat_cnt_a)
    );

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_W_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_b), .sum(sum_b), .sum_valid(sum_valid_b), .sum_ready(sum_ready),
        .overflow(overflow_b), .busy(busy_b), .beat_cnt(beat_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int add_model(input int s, input int p, input int w);
        int lim;
        lim = 1 << w;
        if (s + p >= lim) return SAT ? lim - 1 : s + p - lim;
        return s + p;
    endfunction

    task automatic model_clear();
        m_cnt   = 0;
        m_acc_a = 0;
        m_acc_b = 0;
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_sum_a  = 0;
        m_sum_b  = 0;
    endtask

    // Behavioural view of one clock edge, driven from the inputs currently applied.
    task automatic model_edge();
        int p;
        p = int'(prod);
        if (!rst_n) begin
            model_reset();
        end else if (m_done) begin
            if (sum_ready) m_done = 1'b0;
        end else if (m_active) begin
            if (start) begin
                model_clear();
            end else if (prod_valid) begin
                if (m_acc_a + p >= (1 << ACC_W_A)) m_ovf_a = 1'b1;
                if (m_acc_b + p >= (1 << ACC_W_B)) m_ovf_b = 1'b1;
                m_acc_a = add_model(m_acc_a, p, ACC_W_A);
                m_acc_b = add_model(m_acc_b, p, ACC_W_B);
                m_cnt++;
                if (m_cnt == COUNT) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_sum_a  = m_acc_a;
                    m_sum_b  = m_acc_b;
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            model_clear();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkAll(input string step);
        checkOutput({step, ":prod_ready_a"}, 32'(prod_ready_a), 32'(m_active));
        checkOutput({step, ":busy_a"},       32'(busy_a),       32'(m_active | m_done));
        checkOutput({step, ":sum_valid_a"},  32'(sum_valid_a),  32'(m_done));
        checkOutput({step, ":beat_cnt_a"},   32'(beat_cnt_a),   32'(m_cnt));
        checkOutput({step, ":sum_a"},        32'(sum_a),        32'(m_sum_a));
        checkOutput({step, ":overflow_a"},   32'(overflow_a),   32'(m_ovf_a));
        checkOutput({step, ":prod_ready_b"}, 32'(prod_ready_b), 32'(m_active));
        checkOutput({step, ":busy_b"},       32'(busy_b),       32'(m_active | m_done));
        checkOutput({step, ":sum_valid_b"},  32'(sum_valid_b),  32'(m_done));
        checkOutput({step, ":beat_cnt_b"},   32'(beat_cnt_b),   32'(m_cnt));
        checkOutput({step, ":sum_b"},        32'(sum_b),        32'(m_sum_b));
        checkOutput({step, ":overflow_b"},   32'(overflow_b),   32'(m_ovf_b));
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [2*WIDTH-1:0] p,
                                 input logic r, input string step);
        start      = s;
        prod_valid = v;
        prod       = p;
        sum_ready  = r;
        model_edge();
        @(posedge clk);
        #1;
        checkAll(step);
    endtask

    initial begin
        int cyc;
        int rise;
        logic [2*WIDTH-1:0] vals_a [4];

        checks_total  = 0;
        checks_passed = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod       = '0;
        sum_ready  = 1'b0;
        model_reset();
        #1;
        checkAll("reset");
        applyStimulus(1'b1, 1'b1, 8'd7, 1'b0, "reset_hold");
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, "reset_hold");
        rst_n = 1'b1;

        $display("[TB] back-to-back products 15,30,45,60");
        vals_a = '{8'd15, 8'd30, 8'd45, 8'd60};
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "A_start");
        cyc  = 1;
        rise = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, vals_a[i], 1'b0, "A_beat");
            cyc++;
            if (sum_valid_a === 1'b1 && rise == 0) rise = cyc;
        end
        checkOutput("A_latency", 32'(rise), 32'd5);
        checkOutput("A_sum", 32'(sum_a), 32'd150);
        checkOutput("A_overflow", 32'(overflow_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, "A_drain");

        $display("[TB] four products of 225");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "B_start");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'd225, 1'b0, "B_beat");
        checkOutput("B_sum_wide", 32'(sum_a), 32'd900);
        checkOutput("B_ovf_wide", 32'(overflow_a), 32'd0);
        checkOutput("B_sum_narrow", 32'(sum_b), SAT ? 32'd511 : 32'd388);
        checkOutput("B_ovf_narrow", 32'(overflow_b), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, "B_drain");

        $display("[TB] toggling prod_valid, delayed sum_ready");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "C_start");
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, (i % 2) == 0, 8'($urandom_range(0, 225)), 1'b0, "C_toggle");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 225)), 1'b0, "C_hold");
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, "C_drain");
        checkOutput("C_idle_busy", 32'(busy_a), 32'd0);

        $display("[TB] restart during accumulation");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "D_start");
        applyStimulus(1'b0, 1'b1, 8'd10, 1'b0, "D_beat");
        applyStimulus(1'b0, 1'b1, 8'd20, 1'b0, "D_beat");
        applyStimulus(1'b1, 1'b1, 8'd99, 1'b0, "D_restart");
        checkOutput("D_beat_cnt_cleared", 32'(beat_cnt_a), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'd1, 1'b0, "D_beat");
        checkOutput("D_sum", 32'(sum_a), 32'd4);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, "D_drain");

        $display("[TB] prod_valid in IDLE, start in DONE");
        applyStimulus(1'b0, 1'b1, 8'd50, 1'b0, "E_idle_valid");
        applyStimulus(1'b0, 1'b1, 8'd60, 1'b1, "E_idle_valid");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "E_start");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 225)), 1'b0, "E_beat");
        applyStimulus(1'b1, 1'b1, 8'd5, 1'b0, "E_start_in_done");
        checkOutput("E_still_done", 32'(sum_valid_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, "E_drain");

        $display("[TB] asynchronous reset mid-accumulation");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, "F_start");
        applyStimulus(1'b0, 1'b1, 8'd33, 1'b0, "F_beat");
        applyStimulus(1'b0, 1'b1, 8'd44, 1'b0, "F_beat");
        rst_n = 1'b0;
        #1;
        model_reset();
        checkAll("F_async");
        applyStimulus(1'b0, 1'b1, 8'd12, 1'b0, "F_held");
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd12, 1'b0, "F_after");

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom % 12) == 0, $urandom_range(0, 1) == 1,
                          8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, "G_random");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the team's combinational array multiplier.
- Takes the 2*WIDTH-bit product, one per valid/ready handshake, and accumulates COUNT products into a dot-product sum.
- Presents the finished sum on a valid/ready output port with an overflow flag.
- The multiplier feeds prod; the consumer (display/ALU stage) drains sum.

Parameters:
WIDTH, 4, multiplier operand width; product input is 2*WIDTH bits
COUNT, 4, products per accumulation, >= 1
ACC_WIDTH, 2*WIDTH+2, accumulator/sum width, >= 2*WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle pulse: begin a new accumulation
prod  in  2*WIDTH  product from multiplier
prod_valid  in  1  prod is valid this cycle
prod_ready  out  1  block accepts prod this cycle
sum  out  ACC_WIDTH  accumulated result
sum_valid  out  1  sum is valid, held until accepted
sum_ready  in  1  consumer accepts sum
overflow  out  1  sticky: accumulation exceeded ACC_WIDTH bits
busy  out  1  high in ACCUM or DONE
beat_cnt  out  $clog2(COUNT+1)  products accepted so far this run

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion is asynchronous; deassertion is sampled on clk.
- Reset values:
  - FSM = IDLE
  - acc = 0, sum = 0, beat_cnt = 0
  - prod_ready = 0, sum_valid = 0, overflow = 0, busy = 0
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready = 0.
  - start = 1 -> acc, beat_cnt and overflow clear to 0; next state ACCUM.
- ACCUM:
  - prod_ready = 1 (combinational from state only; never depends on prod_valid).
  - Beat = prod_valid & prod_ready.
  - On each beat: acc <= acc + zero-extended prod; beat_cnt increments.
  - On the beat that makes beat_cnt == COUNT: next state DONE.
- DONE:
  - sum_valid = 1; sum = acc, registered and stable until handshake.
  - prod_ready = 0.
  - sum_valid & sum_ready -> IDLE; sum_valid drops the next cycle. sum keeps its last value; beat_cnt is held.
- Latency: sum_valid rises the cycle after the COUNT-th accepted product. With prod_valid held high and COUNT=4: start at cycle 0, beats at cycles 1-4, sum_valid at cycle 5.
- Arithmetic:
  - Unsigned.
  - The add is computed ACC_WIDTH+1 bits wide. If the carry-out is 1, overflow is set and stays set until the next start.
  - Without the optional feature, acc wraps modulo 2^ACC_WIDTH.
- Boundary conditions:
  - start while in ACCUM: restart. acc, beat_cnt and overflow clear, state stays ACCUM, and any beat in that same cycle is discarded (start wins).
  - start while in DONE: ignored; the sum must be drained first.
  - COUNT = 1: the first beat goes straight to DONE.
  - prod_valid in IDLE or DONE: ignored, no state change.
  - sum_ready without sum_valid: no effect.
  - rst_n low at any point, including mid-accumulation or in DONE: immediate return to reset values; the partial sum is lost.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined: on carry-out, acc saturates to 2^ACC_WIDTH-1 and stays there for the rest of the run; overflow is still set.
- Undefined: wrap-around as above. overflow behaves identically in both builds.

Decomposition:
- Package mult_pkg: typedef enum logic [1:0] acc_state_t {IDLE, ACCUM, DONE}, plus a function for the ACC_WIDTH+1-bit add with carry.
- No sub-module needed: the single FSM and datapath fit one module.
- Integration top instantiates the existing multiplier feeding prod.

Test Plan:
- WIDTH=4, COUNT=4, ACC_WIDTH=10: start, then prods 15,30,45,60 back-to-back -> sum=150, overflow=0, sum_valid at cycle 5.
- Four prods of 225 (15*15) -> sum=900, overflow=0. Same with ACC_WIDTH=9 -> sum=388 and overflow=1 without the macro; sum=511 and overflow=1 with PRODUCT_ACCUMULATOR_SAT_EN.
- prod_valid toggling 1,0,1,0...; then sum_ready held low 3 cycles after DONE -> only valid beats counted, sum stable and sum_valid high until sum_ready=1, then IDLE.
- start asserted after 2 beats (values 10,20) with prod_valid=1 in the same cycle -> beat discarded, beat_cnt=0, then 4 new prods of 1 -> sum=4.
- rst_n pulsed low mid-ACCUM (beat_cnt=2) -> all outputs return to 0 immediately with no clock edge required. prod_valid in IDLE and start in DONE are ignored.
